vmmul_sequencer: RTL and testbench

- Multi-cycle controller for the MatX vector matrix-multiply instruction. Decode flags it as vector-mmul and the control unit selects the vector write path.
- Accepts one mmul issue from the control unit and computes C = A x B for DIM x DIM matrices. Row i of each matrix is held in vector register base+i.
- For each output row, sequences vector-register-file reads, the MAC unit's accumulate controls and the write-back.
- Stalls the scalar pipeline until the operation completes.

---
 rtl/vmmul_sequencer_if.sv | 35 +++
 rtl/vmmul_sequencer.sv | 147 ++++++++++++++
 tb/tb_vmmul_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmmul_sequencer_if.sv
// Issue and datapath-control bundle for the vector matrix-multiply sequencer.
// The master side is the control unit / VRF / MAC; the slave side is the sequencer.
interface vmmul_sequencer_if #(
  parameter int DIM     = 4,
  parameter int VREG_AW = 5,
  parameter int IDX_W   = $clog2(DIM)
);
  logic               start_i;
  logic [VREG_AW-1:0] vs1_base_i;
  logic [VREG_AW-1:0] vs2_base_i;
  logic [VREG_AW-1:0] vd_base_i;
  logic               flush_i;
  logic [VREG_AW-1:0] vrf_rd_a_addr_o;
  logic [VREG_AW-1:0] vrf_rd_b_addr_o;
  logic [IDX_W-1:0]   elem_sel_o;
  logic               mac_en_o;
  logic               mac_clr_o;
  logic               vrf_wr_en_o;
  logic [VREG_AW-1:0] vrf_wr_addr_o;
  logic               busy_o;
  logic               stall_o;
  logic               done_o;

  modport master (
    output start_i, vs1_base_i, vs2_base_i, vd_base_i, flush_i,
    input  vrf_rd_a_addr_o, vrf_rd_b_addr_o, elem_sel_o, mac_en_o, mac_clr_o,
           vrf_wr_en_o, vrf_wr_addr_o, busy_o, stall_o, done_o
  );

  modport slave (
    input  start_i, vs1_base_i, vs2_base_i, vd_base_i, flush_i,
    output vrf_rd_a_addr_o, vrf_rd_b_addr_o, elem_sel_o, mac_en_o, mac_clr_o,
           vrf_wr_en_o, vrf_wr_addr_o, busy_o, stall_o, done_o
  );
endinterface

// File: rtl/vmmul_sequencer.sv
// Multi-cycle sequencer for the vector matrix-multiply instruction C = A x B.
// For each output row i it steps k = 0..DIM-1 through the MAC (reading A row i
// and B row k), then writes the accumulator to vd+i. The scalar pipeline is
// stalled from the issue cycle until the DONE cycle.
module vmmul_sequencer #(
  parameter int DIM     = 4,
  parameter int VREG_AW = 5,
  parameter int IDX_W   = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              reset_n,
  vmmul_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [IDX_W-1:0]   row_idx;
  logic [IDX_W-1:0]   row_nxt;
  logic [IDX_W-1:0]   k_idx;
  logic [IDX_W-1:0]   k_nxt;
  logic               accept;
  logic [VREG_AW-1:0] vs1_q;
  logic [VREG_AW-1:0] vs2_q;
  logic [VREG_AW-1:0] vd_q;

  // Register-file addresses wrap modulo 2^VREG_AW.
  function automatic logic [VREG_AW-1:0] wrap_add(input logic [VREG_AW-1:0] base,
                                                  input logic [IDX_W-1:0]   idx);
    return base + VREG_AW'(idx);
  endfunction

  // Next-state and counter sequencing; flush abandons the operation from MAC or WB.
  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    k_nxt     = k_idx;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          accept    = 1'b1;
          state_nxt = S_MAC;
          row_nxt   = '0;
          k_nxt     = '0;
        end
      end
      S_MAC: begin
        if (bus.flush_i) begin
          state_nxt = S_IDLE;
          row_nxt   = '0;
          k_nxt     = '0;
        end else if (k_idx == IDX_LAST) begin
          state_nxt = S_WB;
        end else begin
          k_nxt = k_idx + 1'b1;
        end
      end
      S_WB: begin
        if (bus.flush_i) begin
          state_nxt = S_IDLE;
          row_nxt   = '0;
          k_nxt     = '0;
        end else if (row_idx == IDX_LAST) begin
          state_nxt = S_DONE;
          row_nxt   = '0;
          k_nxt     = '0;
        end else begin
          state_nxt = S_MAC;
          row_nxt   = row_idx + 1'b1;
          k_nxt     = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        row_nxt   = '0;
        k_nxt     = '0;
      end
    endcase
  end

  // State and row/element counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      row_idx <= '0;
      k_idx   <= '0;
    end else begin
      state   <= state_nxt;
      row_idx <= row_nxt;
      k_idx   <= k_nxt;
    end
  end

  // Matrix bases are captured only when an issue is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs1_q <= '0;
      vs2_q <= '0;
      vd_q  <= '0;
    end else if (accept) begin
      vs1_q <= bus.vs1_base_i;
      vs2_q <= bus.vs2_base_i;
      vd_q  <= bus.vd_base_i;
    end
  end

  // Output decode from state and counters; only stall_o looks at start_i.
  always_comb begin
    bus.vrf_rd_a_addr_o = '0;
    bus.vrf_rd_b_addr_o = '0;
    bus.elem_sel_o      = '0;
    bus.mac_en_o        = 1'b0;
    bus.mac_clr_o       = 1'b0;
    bus.vrf_wr_en_o     = 1'b0;
    bus.vrf_wr_addr_o   = '0;
    bus.done_o          = 1'b0;
    case (state)
      S_MAC: begin
        bus.mac_en_o        = 1'b1;
        bus.mac_clr_o       = (k_idx == '0);
        bus.vrf_rd_a_addr_o = wrap_add(vs1_q, row_idx);
        bus.vrf_rd_b_addr_o = wrap_add(vs2_q, k_idx);
        bus.elem_sel_o      = k_idx;
      end
      S_WB: begin
        bus.vrf_wr_en_o   = 1'b1;
        bus.vrf_wr_addr_o = wrap_add(vd_q, row_idx);
      end
      S_DONE: begin
        bus.done_o = 1'b1;
      end
      default: begin
      end
    endcase
    bus.busy_o  = (state != S_IDLE);
    // The issue cycle itself must hold the pipeline; reset forces every output low.
    bus.stall_o = (bus.start_i & reset_n) | (state == S_MAC) | (state == S_WB);
  end

endmodule

// File: tb/tb_vmmul_sequencer.sv
// Directed bench for vmmul_sequencer at DIM=4, VREG_AW=5.
// Cycle c of a scenario: inputs applied at the falling edge, outputs sampled 1 ns later.
module tb_vmmul_sequencer;

  localparam int DIM     = 4;
  localparam int VREG_AW = 5;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] elem;
    logic       mac_en;
    logic       mac_clr;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic       busy;
    logic       stall;
    logic       done;
  } outs_t;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  vmmul_sequencer_if #(.DIM(DIM), .VREG_AW(VREG_AW)) bus ();

  vmmul_sequencer #(.DIM(DIM), .VREG_AW(VREG_AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t obs();
    outs_t o;
    o.a       = bus.vrf_rd_a_addr_o;
    o.b       = bus.vrf_rd_b_addr_o;
    o.elem    = bus.elem_sel_o;
    o.mac_en  = bus.mac_en_o;
    o.mac_clr = bus.mac_clr_o;
    o.wr_en   = bus.vrf_wr_en_o;
    o.wr_addr = bus.vrf_wr_addr_o;
    o.busy    = bus.busy_o;
    o.stall   = bus.stall_o;
    o.done    = bus.done_o;
    return o;
  endfunction

  // Expected outputs c cycles after an accepted start, from the documented timeline:
  // cycles 1..20 are 4 rows of (4 MAC + 1 WB), cycle 21 is DONE.
  function automatic outs_t exp_at(int c, logic [4:0] vs1, logic [4:0] vs2,
                                   logic [4:0] vd, logic st);
    outs_t e;
    int row;
    int pos;
    e = '0;
    if (c >= 1 && c <= 20) begin
      row     = (c - 1) / 5;
      pos     = (c - 1) % 5;
      e.busy  = 1'b1;
      e.stall = 1'b1;
      if (pos < 4) begin
        e.mac_en  = 1'b1;
        e.mac_clr = (pos == 0);
        e.a       = vs1 + 5'(row);
        e.b       = vs2 + 5'(pos);
        e.elem    = 2'(pos);
      end else begin
        e.wr_en   = 1'b1;
        e.wr_addr = vd + 5'(row);
      end
    end else if (c == 21) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end
    if (st) e.stall = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    outs_t o;
    reset_n        = 1'b0;
    bus.start_i    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.vs1_base_i = 5'd7;
    bus.vs2_base_i = 5'd7;
    bus.vd_base_i  = 5'd7;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      o = obs();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, o, outs_t'(0));
      end
    end
    @(negedge clk);
    reset_n     = 1'b1;
    bus.start_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      o = obs();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, o, outs_t'(0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    outs_t o;
    outs_t e;
    int n_mac = 0;
    int n_clr = 0;
    int n_wr = 0;
    int n_done = 0;
    int n_stall = 0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      bus.start_i = (c == 0);
      bus.flush_i = 1'b0;
      if (c == 0) begin
        bus.vs1_base_i = 5'd8;
        bus.vs2_base_i = 5'd16;
        bus.vd_base_i  = 5'd24;
      end
      #1;
      o = obs();
      e = exp_at(c, 5'd8, 5'd16, 5'd24, c == 0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", c, o, e);
      end
      if (o.mac_en === 1'b1) n_mac++;
      if (o.mac_en === 1'b1 && o.mac_clr === 1'b1) n_clr++;
      if (o.wr_en === 1'b1) n_wr++;
      if (o.done === 1'b1) n_done++;
      if (o.stall === 1'b1) n_stall++;
    end
    checks++;
    if (n_mac !== 16) begin errors++; $display("FAIL basic_mac_count got=%0d exp=16", n_mac); end
    checks++;
    if (n_clr !== 4) begin errors++; $display("FAIL basic_clr_count got=%0d exp=4", n_clr); end
    checks++;
    if (n_wr !== 4) begin errors++; $display("FAIL basic_wr_count got=%0d exp=4", n_wr); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
    checks++;
    if (n_stall !== 21) begin errors++; $display("FAIL basic_stall_count got=%0d exp=21", n_stall); end
  endtask

  task automatic test_wrap();
    outs_t o;
    outs_t e;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      bus.start_i = (c == 0);
      bus.flush_i = 1'b0;
      if (c == 0) begin
        bus.vs1_base_i = 5'd3;
        bus.vs2_base_i = 5'd30;
        bus.vd_base_i  = 5'd29;
      end
      #1;
      o = obs();
      e = exp_at(c, 5'd3, 5'd30, 5'd29, c == 0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", c, o, e);
      end
    end
  endtask

  task automatic test_start_busy();
    outs_t o;
    outs_t e;
    int n_wr = 0;
    int n_done = 0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      bus.start_i = (c == 0) || (c == 3) || (c == 21);
      bus.flush_i = 1'b0;
      if (c == 0) begin
        bus.vs1_base_i = 5'd8;
        bus.vs2_base_i = 5'd16;
        bus.vd_base_i  = 5'd24;
      end else if (c == 3) begin
        bus.vs1_base_i = 5'd1;
        bus.vs2_base_i = 5'd2;
        bus.vd_base_i  = 5'd3;
      end else if (c == 21) begin
        bus.vs1_base_i = 5'd5;
        bus.vs2_base_i = 5'd6;
        bus.vd_base_i  = 5'd7;
      end
      #1;
      o = obs();
      e = exp_at(c, 5'd8, 5'd16, 5'd24, bus.start_i);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_busy cyc=%0d got=%h exp=%h", c, o, e);
      end
      if (o.wr_en === 1'b1) n_wr++;
      if (o.done === 1'b1) n_done++;
    end
    checks++;
    if (n_wr !== 4) begin errors++; $display("FAIL start_busy_wr_count got=%0d exp=4", n_wr); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL start_busy_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_flush();
    outs_t o;
    outs_t e;
    int n_wr = 0;
    int n_done = 0;
    int r;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      bus.start_i = (c == 0) || (c == 13) || (c == 15);
      bus.flush_i = (c == 7) || (c == 13) || (c == 20);
      bus.vs1_base_i = 5'd8;
      bus.vs2_base_i = 5'd16;
      bus.vd_base_i  = 5'd24;
      #1;
      o = obs();
      if (c <= 7) begin
        e = exp_at(c, 5'd8, 5'd16, 5'd24, c == 0);
      end else if (c == 13) begin
        e = '0;
        e.stall = 1'b1;
      end else if (c >= 15) begin
        r = c - 15;
        e = (r <= 5) ? exp_at(r, 5'd8, 5'd16, 5'd24, r == 0) : outs_t'(0);
      end else begin
        e = '0;
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL flush cyc=%0d got=%h exp=%h", c, o, e);
      end
      if (o.wr_en === 1'b1) n_wr++;
      if (o.done === 1'b1) n_done++;
    end
    checks++;
    if (n_wr !== 2) begin errors++; $display("FAIL flush_wr_count got=%0d exp=2", n_wr); end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL flush_done_count got=%0d exp=0", n_done); end
  endtask

  task automatic test_async_reset();
    outs_t o;
    outs_t e;
    int n_done = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      bus.start_i = (c == 0);
      bus.flush_i = 1'b0;
      bus.vs1_base_i = 5'd8;
      bus.vs2_base_i = 5'd16;
      bus.vd_base_i  = 5'd24;
      #1;
      o = obs();
      e = exp_at(c, 5'd8, 5'd16, 5'd24, c == 0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL areset_pre cyc=%0d got=%h exp=%h", c, o, e);
      end
    end
    #1;
    reset_n = 1'b0;
    #1;
    o = obs();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL areset_immediate got=%h exp=%h", o, outs_t'(0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    o = obs();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL areset_release got=%h exp=%h", o, outs_t'(0));
    end
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      bus.start_i = (c == 0);
      bus.flush_i = 1'b0;
      bus.vs1_base_i = 5'd4;
      bus.vs2_base_i = 5'd9;
      bus.vd_base_i  = 5'd30;
      #1;
      o = obs();
      e = exp_at(c, 5'd4, 5'd9, 5'd30, c == 0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL areset_rerun cyc=%0d got=%h exp=%h", c, o, e);
      end
      if (o.done === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL areset_done_count got=%0d exp=1", n_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_start_busy();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
